// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch sequencer: state encodings,
// control-word bit positions and per-state control-word constants.
package stopwatch_pkg;

   typedef enum logic [2:0] {
      StClear   = 3'd0,
      StIdle    = 3'd1,
      StRun     = 3'd2,
      StLapCap  = 3'd3,
      StLapShow = 3'd4,
      StStop    = 3'd5
   } state_e;

   localparam int unsigned CW_CNT_EN   = 0;
   localparam int unsigned CW_CNT_CLR  = 1;
   localparam int unsigned CW_LAP_LD   = 2;
   localparam int unsigned CW_LAP_CLR  = 3;
   localparam int unsigned CW_DISP_SEL = 4;
   localparam int unsigned CW_RUN_LED  = 5;

   // cnt_en is never part of these; it is added from tenth while running.
   localparam logic [5:0] CLEAR_CW   = 6'b001010;
   localparam logic [5:0] IDLE_CW    = 6'b000000;
   localparam logic [5:0] RUN_CW     = 6'b100000;
   localparam logic [5:0] LAPCAP_CW  = 6'b100100;
   localparam logic [5:0] LAPSHOW_CW = 6'b110000;
   localparam logic [5:0] STOP_CW    = 6'b000000;

endpackage

// File: rtl/press_detect.sv
// Rising-edge detector for a debounced, synchronized button level.
// Ports:
//   i_clk   - system clock
//   i_reset - synchronous active-high reset; loads prev=1 so a button held
//             through reset only fires after release and re-press
//   i_btn   - button level
//   o_press - one-cycle pulse when i_btn is high and was low last cycle
module press_detect (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_btn,
   output logic o_press
);

   logic r_prev;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_prev <= 1'b1;
      end else begin
         r_prev <= i_btn;
      end
   end

   assign o_press = i_btn & ~r_prev;

endmodule

// File: rtl/stopwatch_sequencer.sv
// Stopwatch sequencer: converts start/stop and lap/clear button presses plus
// the tenth-second tick into the datapath control word, with a timed lap hold.
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset
//   btn_ss  - start/stop button level
//   btn_lap - lap/clear button level
//   tenth   - one-clock pulse every 0.1 s
//   cw      - [0]cnt_en [1]cnt_clr [2]lap_ld [3]lap_clr [4]disp_sel [5]run_led
//   state_o - current state encoding
module stopwatch_sequencer
   import stopwatch_pkg::*;
#(
   parameter int unsigned HOLD_TICKS = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_ss,
   input  logic       btn_lap,
   input  logic       tenth,
   output logic [5:0] cw,
   output logic [2:0] state_o
);

   localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

   state_e          r_state;
   state_e          w_state_d;
   logic [HW-1:0]   r_hold;
   logic [HW-1:0]   w_hold_d;
   logic            w_ss;
   logic            w_lp;
   logic            w_running;
   logic [5:0]      w_cw_base;

   press_detect u_pd_ss (
      .i_clk   (clk),
      .i_reset (reset),
      .i_btn   (btn_ss),
      .o_press (w_ss)
   );

   press_detect u_pd_lap (
      .i_clk   (clk),
      .i_reset (reset),
      .i_btn   (btn_lap),
      .o_press (w_lp)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StClear;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_d;
         r_hold  <= w_hold_d;
      end
   end

   // Start/stop has priority over lap everywhere; a press beats hold expiry.
   always_comb begin
      w_state_d = StClear;
      unique case (r_state)
         StClear:  w_state_d = StIdle;
         StIdle:   w_state_d = w_ss ? StRun : StIdle;
         StRun: begin
            if (w_ss)      w_state_d = StStop;
            else if (w_lp) w_state_d = StLapCap;
            else           w_state_d = StRun;
         end
         StLapCap: w_state_d = w_ss ? StStop : StLapShow;
         StLapShow: begin
            if (w_ss)                            w_state_d = StStop;
            else if (w_lp)                       w_state_d = StLapCap;
            else if (tenth && r_hold == HW'(1))  w_state_d = StRun;
            else                                 w_state_d = StLapShow;
         end
         StStop: begin
            if (w_ss)      w_state_d = StRun;
            else if (w_lp) w_state_d = StClear;
            else           w_state_d = StStop;
         end
         default:  w_state_d = StClear;
      endcase
   end

   // Hold counter saturates at zero; its value only matters in StLapShow.
   always_comb begin
      w_hold_d = r_hold;
      if (r_state == StLapCap) begin
         w_hold_d = HW'(HOLD_TICKS);
      end else if (r_state == StLapShow && tenth && r_hold != '0) begin
         w_hold_d = r_hold - HW'(1);
      end
   end

   always_comb begin
      w_cw_base = CLEAR_CW;
      w_running = 1'b0;
      unique case (r_state)
         StClear:   w_cw_base = CLEAR_CW;
         StIdle:    w_cw_base = IDLE_CW;
         StRun: begin
            w_cw_base = RUN_CW;
            w_running = 1'b1;
         end
         StLapCap: begin
            w_cw_base = LAPCAP_CW;
            w_running = 1'b1;
         end
         StLapShow: begin
            w_cw_base = LAPSHOW_CW;
            w_running = 1'b1;
         end
         StStop:    w_cw_base = STOP_CW;
         default:   w_cw_base = CLEAR_CW;
      endcase
   end

   // cnt_en is the only Mealy bit: ticks count in every running state.
   always_comb begin
      cw            = w_cw_base;
      cw[CW_CNT_EN] = tenth & w_running;
   end

   assign state_o = r_state;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Directed bench for stopwatch_sequencer with HOLD_TICKS=3. Each stimulus
// cycle pushes the hand-computed cw/state for that cycle into a queue; a
// monitor pops and compares on the falling edge.
module tb_stopwatch_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_ss = 1'b0;
   logic       btn_lap = 1'b0;
   logic       tenth = 1'b0;
   logic [5:0] cw;
   logic [2:0] state_o;

   int n_checks = 0;
   int n_errors = 0;
   bit done = 1'b0;

   typedef struct {
      logic [5:0] cw;
      logic [2:0] st;
      string      nm;
   } exp_t;

   exp_t sb[$];

   localparam logic [2:0] C = 3'd0, I = 3'd1, R = 3'd2, LC = 3'd3, LS = 3'd4, S = 3'd5;

   stopwatch_sequencer #(.HOLD_TICKS(3)) dut (
      .clk     (clk),
      .reset   (reset),
      .btn_ss  (btn_ss),
      .btn_lap (btn_lap),
      .tenth   (tenth),
      .cw      (cw),
      .state_o (state_o)
   );

   always #5 clk = ~clk;

   // Drive one cycle's inputs just after the rising edge and queue the
   // outputs expected during that cycle.
   task automatic cyc(input logic ss, input logic lp, input logic tk, input logic rst,
                      input bit chk, input logic [5:0] ecw, input logic [2:0] est,
                      input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      btn_ss  = ss;
      btn_lap = lp;
      tenth   = tk;
      reset   = rst;
      if (chk) begin
         e.cw = ecw;
         e.st = est;
         e.nm = nm;
         sb.push_back(e);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            if (cw !== e.cw) begin
               n_errors++;
               $display("FAIL %s cw: got %b expected %b", e.nm, cw, e.cw);
            end
            n_checks++;
            if (state_o !== e.st) begin
               n_errors++;
               $display("FAIL %s state: got %0d expected %0d", e.nm, state_o, e.st);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      if (!done) begin
         $display("FAIL watchdog: timeout, got no finish expected finish");
         $fatal(1, "timeout");
      end
   end

   initial begin : stim
      // 1: reset, CLEAR for one cycle, then IDLE
      cyc(0, 0, 0, 1, 0, 6'h00, C,  "rst0");
      cyc(0, 0, 0, 1, 1, 6'h0A, C,  "rst1");
      cyc(0, 0, 0, 0, 1, 6'h0A, C,  "clear_after_rst");
      cyc(0, 0, 0, 0, 1, 6'h00, I,  "idle");
      cyc(0, 0, 1, 0, 1, 6'h00, I,  "idle_tenth");
      // 2: run for 5 tenths, then stop
      cyc(1, 0, 0, 0, 1, 6'h00, I,  "ss_in_idle");
      cyc(0, 0, 1, 0, 1, 6'h21, R,  "run_t1");
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 1, 6'h21, R, "run_tn");
      cyc(0, 0, 0, 0, 1, 6'h20, R,  "run_not");
      cyc(1, 0, 0, 0, 1, 6'h20, R,  "ss_in_run");
      cyc(0, 0, 1, 0, 1, 6'h00, S,  "stop_t1");
      cyc(0, 0, 1, 0, 1, 6'h00, S,  "stop_t2");
      cyc(1, 0, 0, 0, 1, 6'h00, S,  "ss_in_stop");
      cyc(0, 0, 0, 0, 1, 6'h20, R,  "rerun");
      // 3: lap capture and 3-tick hold
      cyc(0, 1, 0, 0, 1, 6'h20, R,  "lp_in_run");
      cyc(0, 0, 0, 0, 1, 6'h24, LC, "lapcap");
      cyc(0, 0, 1, 0, 1, 6'h31, LS, "show_t1");
      cyc(0, 0, 0, 0, 1, 6'h30, LS, "show_nt");
      cyc(0, 0, 1, 0, 1, 6'h31, LS, "show_t2");
      cyc(0, 0, 1, 0, 1, 6'h31, LS, "show_t3");
      cyc(0, 0, 0, 0, 1, 6'h20, R,  "hold_expired");
      // tick during capture still counts; ss at expiry wins
      cyc(0, 1, 0, 0, 1, 6'h20, R,  "lp2_in_run");
      cyc(0, 0, 1, 0, 1, 6'h25, LC, "lapcap_tick");
      cyc(0, 0, 1, 0, 1, 6'h31, LS, "show2_t1");
      cyc(0, 0, 1, 0, 1, 6'h31, LS, "show2_t2");
      cyc(1, 0, 1, 0, 1, 6'h31, LS, "ss_at_expiry");
      cyc(0, 0, 0, 0, 1, 6'h00, S,  "stop_from_show");
      // 4: simultaneous ss+lp in RUN, then lp in STOP clears
      cyc(1, 0, 0, 0, 1, 6'h00, S,  "ss_from_stop");
      cyc(0, 0, 0, 0, 1, 6'h20, R,  "run4");
      cyc(1, 1, 0, 0, 1, 6'h20, R,  "both_in_run");
      cyc(0, 0, 0, 0, 1, 6'h00, S,  "ss_wins");
      cyc(0, 1, 0, 0, 1, 6'h00, S,  "lp_in_stop");
      cyc(0, 0, 0, 0, 1, 6'h0A, C,  "clear_from_stop");
      cyc(0, 0, 0, 0, 1, 6'h00, I,  "idle4");
      // 5: ss held across reset does not start
      cyc(1, 0, 0, 1, 1, 6'h00, I,  "rst_with_ss");
      cyc(1, 0, 0, 0, 1, 6'h0A, C,  "clear5");
      cyc(1, 0, 0, 0, 1, 6'h00, I,  "held_ss1");
      cyc(1, 0, 0, 0, 1, 6'h00, I,  "held_ss2");
      cyc(0, 0, 0, 0, 1, 6'h00, I,  "released");
      cyc(1, 0, 0, 0, 1, 6'h00, I,  "repress");
      cyc(0, 0, 0, 0, 1, 6'h20, R,  "run5");
      // 6: reset mid-hold
      cyc(0, 1, 0, 0, 1, 6'h20, R,  "lp6");
      cyc(0, 0, 0, 0, 1, 6'h24, LC, "lapcap6");
      cyc(0, 0, 1, 0, 1, 6'h31, LS, "show6_t1");
      cyc(0, 0, 0, 1, 1, 6'h30, LS, "rst_in_show");
      cyc(0, 0, 0, 0, 1, 6'h0A, C,  "clear6");
      cyc(0, 0, 0, 0, 1, 6'h00, I,  "idle6");
      cyc(0, 1, 0, 0, 1, 6'h00, I,  "lp_in_idle");
      cyc(0, 0, 0, 0, 1, 6'h00, I,  "idle6_end");
      // let the monitor drain the queue, bounded
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      done = 1'b1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
